// File: rtl/fifo_serial_drain_pkg.sv
// Shared definitions for the 4-deep FIFO, its writer and the serial drain.
package fifo_pkg;

    localparam int unsigned DATA_W_DEFAULT = 2;
    localparam int unsigned FIFO_DEPTH     = 4;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        START,
        DATA,
        STOP
    } drain_state_e;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_serial_drain_timer.sv
// Loadable down-counter; tick marks the last cycle of the loaded period.
module bit_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         tick
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/fifo_serial_drain.sv
// Pops FIFO words one at a time and sends each as start / LSB-first data / stop on tx.
module fifo_serial_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [3:0]        word_count
);

    localparam int unsigned STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CW       = cnt_width(STOP_LEN);
    localparam int unsigned BW       = cnt_width(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    drain_state_e      state, state_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic [BW-1:0]     bit_idx, bit_idx_next;
    logic              tick, load, frame_end, tx_next;
    logic [CW-1:0]     load_value;

    bit_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_value),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        load         = 1'b0;
        load_value   = CW'(CLKS_PER_BIT - 1);
        frame_end    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                shift_next = fifo_data;
                load       = 1'b1;
                state_next = START;
            end
            START: begin
                if (tick) begin
                    load         = 1'b1;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    load = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        load_value = CW'(STOP_LEN - 1);
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    frame_end  = 1'b1;
                    state_next = (enable && !fifo_empty) ? POP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Line level is precomputed from the next state so tx comes straight off a flop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            fifo_pop   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            word_count <= '0;
        end else begin
            shift      <= shift_next;
            bit_idx    <= bit_idx_next;
            tx         <= tx_next;
            fifo_pop   <= (state_next == POP);
            busy       <= (state_next != IDLE);
            frame_done <= frame_end;
            if (frame_end) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule
